// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR tap loader: sequencer state encoding
// and the index-width helper used to derive tap and bank address widths.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Address width for n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_loader_if.sv
// Host-config, load-request, sample-stream and filter-side signals of the tap loader.
// slave = loader side, master = host/filter side.
interface fir_tap_loader_if
    import fir_ctrl_pkg::*;
#(
    parameter int NTAPS  = 128,
    parameter int TW     = 12,
    parameter int IW     = 12,
    parameter int NBANKS = 4
);
    localparam int LGNT = idx_w(NTAPS);
    localparam int LGNB = idx_w(NBANKS);

    logic            i_cfg_wr;
    logic [LGNB-1:0] i_cfg_bank;
    logic [LGNT-1:0] i_cfg_addr;
    logic [TW-1:0]   i_cfg_data;
    logic            i_load_req;
    logic [LGNB-1:0] i_load_bank;
    logic            i_ce;
    logic [IW-1:0]   i_sample;
    logic            o_ce;
    logic [IW-1:0]   o_sample;
    logic            o_tap_wr;
    logic [TW-1:0]   o_tap;
    logic            o_busy;
    logic            o_done;
    logic            o_overrun;

    modport slave (
        input  i_cfg_wr, i_cfg_bank, i_cfg_addr, i_cfg_data,
        input  i_load_req, i_load_bank, i_ce, i_sample,
        output o_ce, o_sample, o_tap_wr, o_tap, o_busy, o_done, o_overrun
    );

    modport master (
        output i_cfg_wr, i_cfg_bank, i_cfg_addr, i_cfg_data,
        output i_load_req, i_load_bank, i_ce, i_sample,
        input  o_ce, o_sample, o_tap_wr, o_tap, o_busy, o_done, o_overrun
    );

endinterface

// File: rtl/fir_coef_bank.sv
// NBANKS x NTAPS coefficient store: one synchronous write port and one registered
// read port. The read register resets to zero; the array itself is never reset.
module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int  NTAPS  = 128,
    parameter int  TW     = 12,
    parameter int  NBANKS = 4,
    localparam int LGNT   = idx_w(NTAPS),
    localparam int LGNB   = idx_w(NBANKS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [LGNB-1:0] wr_bank,
    input  logic [LGNT-1:0] wr_addr,
    input  logic [TW-1:0]   wr_data,
    input  logic            rd_en,
    input  logic [LGNB-1:0] rd_bank,
    input  logic [LGNT-1:0] rd_addr,
    output logic [TW-1:0]   rd_data
);

    logic [TW-1:0] mem [NBANKS][NTAPS];
    logic          same_addr;

    assign same_addr = wr_en && (wr_bank == rd_bank) && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Read stage: a colliding write is forwarded so the newest value wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= same_addr ? wr_data : mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/fir_tap_loader.sv
// Tap-load sequencer in front of the FIR filter: streams one coefficient bank into
// the filter's tap chain while gating samples. Define FIR_TAP_LOADER_FLUSH_EN to zero-flush the delay line after a load.
module fir_tap_loader
    import fir_ctrl_pkg::*;
#(
    parameter int  NTAPS  = 128,
    parameter int  TW     = 12,
    parameter int  IW     = 12,
    parameter int  NBANKS = 4,
    localparam int LGNT   = idx_w(NTAPS),
    localparam int LGNB   = idx_w(NBANKS)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    fir_tap_loader_if.slave  bus
);

    // One extra count bit lets LOAD spend a drain cycle at cnt == NTAPS.
    localparam int CNT_W = LGNT + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [LGNB-1:0]  bank_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;
    logic             rd_en_p0;
    logic             vld_p1;
    logic             cfg_wr_ok;
    logic             flush_active;
    logic [TW-1:0]    tap_p1;

    assign rd_en_p0  = (state == ST_LOAD) && (cnt < CNT_W'(NTAPS));
    assign cfg_wr_ok = bus.i_cfg_wr && !(busy_q && (bus.i_cfg_bank == bank_q));

`ifdef FIR_TAP_LOADER_FLUSH_EN
    assign flush_active = (state == ST_FLUSH);
`else
    assign flush_active = 1'b0;
`endif

    fir_coef_bank #(
        .NTAPS  (NTAPS),
        .TW     (TW),
        .NBANKS (NBANKS)
    ) u_bank (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .wr_en   (cfg_wr_ok),
        .wr_bank (bus.i_cfg_bank),
        .wr_addr (bus.i_cfg_addr),
        .wr_data (bus.i_cfg_data),
        .rd_en   (rd_en_p0),
        .rd_bank (bank_q),
        .rd_addr (cnt[LGNT-1:0]),
        .rd_data (tap_p1)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bank_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && bus.i_ce) begin
                overrun_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.i_load_req) begin
                        state     <= ST_LOAD;
                        bank_q    <= bus.i_load_bank;
                        cnt       <= '0;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (cnt == CNT_W'(NTAPS)) begin
                        cnt <= '0;
`ifdef FIR_TAP_LOADER_FLUSH_EN
                        state <= ST_FLUSH;
`else
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef FIR_TAP_LOADER_FLUSH_EN
                ST_FLUSH: begin
                    if (cnt == CNT_W'(NTAPS - 1)) begin
                        cnt    <= '0;
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: tap-write valid follows the registered read.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en_p0;
        end
    end

    // Sample mux: passthrough when idle or done, zeros while flushing, gated otherwise.
    always_comb begin
        bus.o_ce     = 1'b0;
        bus.o_sample = '0;
        if (i_reset_n) begin
            if (state == ST_IDLE || state == ST_DONE) begin
                bus.o_ce     = bus.i_ce;
                bus.o_sample = bus.i_sample;
            end else if (flush_active) begin
                bus.o_ce = 1'b1;
            end
        end
    end

    assign bus.o_tap_wr  = vld_p1;
    assign bus.o_tap     = tap_p1;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed, table-driven bench for fir_tap_loader (NTAPS=16, NBANKS=4, TW=IW=9).
// Honors FIR_TAP_LOADER_FLUSH_EN for the flush timing.
module tb_fir_tap_loader;

    localparam int NT = 16;
    localparam int NB = 4;
    localparam int W  = 9;
`ifdef FIR_TAP_LOADER_FLUSH_EN
    localparam int F = NT;
`else
    localparam int F = 0;
`endif
    localparam int LEN = 21 + F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_tap_loader_if #(.NTAPS(NT), .TW(W), .IW(W), .NBANKS(NB)) bus ();

    fir_tap_loader #(.NTAPS(NT), .TW(W), .IW(W), .NBANKS(NB)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic         ce;
        logic [W-1:0] smp;
        logic         exp_ce;
        logic [W-1:0] exp_smp;
    } pt_t;

    typedef struct {
        logic tap_wr;
        logic chk_tap;
        int   tap;
        logic busy;
        logic done;
        logic ce;
        int   smp;
        logic ovr;
    } ld_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  model [NB][NT];
    pt_t pt_tab [4];
    ld_t ld_tab [LEN+1];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int b, input int a, input int d);
        bus.i_cfg_wr   = 1'b1;
        bus.i_cfg_bank = b[1:0];
        bus.i_cfg_addr = a[3:0];
        bus.i_cfg_data = d[8:0];
        step();
        bus.i_cfg_wr   = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ce"},     int'(bus.o_ce), 0);
        chk({tag, "_smp"},    int'(bus.o_sample), 0);
        chk({tag, "_tapwr"},  int'(bus.o_tap_wr), 0);
        chk({tag, "_tap"},    int'(bus.o_tap), 0);
        chk({tag, "_busy"},   int'(bus.o_busy), 0);
        chk({tag, "_done"},   int'(bus.o_done), 0);
        chk({tag, "_ovr"},    int'(bus.o_overrun), 0);
    endtask

    // Request a load, collect every tap write and check count, order and done latency.
    task automatic do_load(input int b);
        int taps[$];
        int done_at;
        done_at = -1;
        bus.i_load_bank = b[1:0];
        bus.i_load_req  = 1'b1;
        step();
        bus.i_load_req  = 1'b0;
        for (int k = 1; k <= 80 && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) chk("ovr_cleared_on_accept", int'(bus.o_overrun), 0);
            if (bus.o_tap_wr) taps.push_back(int'(bus.o_tap));
            if (bus.o_done) done_at = k;
            step();
        end
        chk($sformatf("b%0d_done_latency", b), done_at, 18 + F);
        chk($sformatf("b%0d_tap_count", b), taps.size(), NT);
        for (int i = 0; i < taps.size() && i < NT; i++) begin
            chk($sformatf("b%0d_tap%0d", b, i), taps[i], model[b][i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tw_cnt;
        int done_cnt;

        pt_tab[0] = '{1'b1, 9'd5,   1'b1, 9'd5};
        pt_tab[1] = '{1'b0, 9'd5,   1'b0, 9'd5};
        pt_tab[2] = '{1'b1, 9'h1FF, 1'b1, 9'h1FF};
        pt_tab[3] = '{1'b1, 9'h000, 1'b1, 9'h000};

        for (int k = 0; k <= LEN; k++) begin
            ld_tab[k].busy    = (k >= 1) && (k <= 17 + F);
            ld_tab[k].tap_wr  = (k >= 2) && (k <= 17);
            ld_tab[k].chk_tap = (k >= 2);
            ld_tab[k].tap     = (k <= 17) ? k - 1 : 16;
            ld_tab[k].done    = (k == 18 + F);
            ld_tab[k].ce      = ld_tab[k].busy ? ((k >= 18) && (k <= 17 + F)) : 1'b1;
            ld_tab[k].smp     = ld_tab[k].busy ? 0 : 5;
            ld_tab[k].ovr     = (k >= 2);
        end

        bus.i_cfg_wr    = 1'b0;
        bus.i_cfg_bank  = '0;
        bus.i_cfg_addr  = '0;
        bus.i_cfg_data  = '0;
        bus.i_load_req  = 1'b0;
        bus.i_load_bank = '0;
        bus.i_ce        = 1'b1;
        bus.i_sample    = 9'd5;

        // Reset: every output low even with a live upstream strobe.
        #1;
        chk_outputs_zero("rst");
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            bus.i_ce     = pt_tab[i].ce;
            bus.i_sample = pt_tab[i].smp;
            #1;
            chk($sformatf("pt%0d_ce", i),  int'(bus.o_ce), int'(pt_tab[i].exp_ce));
            chk($sformatf("pt%0d_smp", i), int'(bus.o_sample), int'(pt_tab[i].exp_smp));
        end
        chk("idle_busy", int'(bus.o_busy), 0);
        step();

        for (int n = 0; n < NT; n++) begin
            cfg_write(2, n, n + 1);
            model[2][n] = n + 1;
            cfg_write(1, n, n + 32);
            model[1][n] = n + 32;
        end

        // Bank-2 load with i_ce held high, a stray request in LOAD and in DONE,
        // and host writes to the loading bank (discarded) and another bank (kept).
        bus.i_ce        = 1'b1;
        bus.i_sample    = 9'd5;
        bus.i_load_bank = 2'd2;
        bus.i_load_req  = 1'b1;
        tw_cnt   = 0;
        done_cnt = 0;
        for (int k = 0; k <= LEN; k++) begin
            if (k == 1) bus.i_load_req = 1'b0;
            if (k == 5) begin
                bus.i_load_req  = 1'b1;
                bus.i_load_bank = 2'd0;
            end
            if (k == 6) begin
                bus.i_load_req = 1'b0;
                bus.i_cfg_wr   = 1'b1;
                bus.i_cfg_bank = 2'd2;
                bus.i_cfg_addr = 4'd3;
                bus.i_cfg_data = 9'h1FF;
            end
            if (k == 7) begin
                bus.i_cfg_bank = 2'd1;
                model[1][3]    = 'h1FF;
            end
            if (k == 8) bus.i_cfg_wr = 1'b0;
            if (k == 18 + F) bus.i_load_req = 1'b1;
            if (k == 19 + F) bus.i_load_req = 1'b0;
            @(negedge clk);
            if (bus.o_tap_wr) tw_cnt++;
            if (bus.o_done) done_cnt++;
            chk($sformatf("k%0d_tapwr", k), int'(bus.o_tap_wr), int'(ld_tab[k].tap_wr));
            if (ld_tab[k].chk_tap) chk($sformatf("k%0d_tap", k), int'(bus.o_tap), ld_tab[k].tap);
            chk($sformatf("k%0d_busy", k), int'(bus.o_busy), int'(ld_tab[k].busy));
            chk($sformatf("k%0d_done", k), int'(bus.o_done), int'(ld_tab[k].done));
            chk($sformatf("k%0d_ce", k),   int'(bus.o_ce), int'(ld_tab[k].ce));
            chk($sformatf("k%0d_smp", k),  int'(bus.o_sample), ld_tab[k].smp);
            chk($sformatf("k%0d_ovr", k),  int'(bus.o_overrun), int'(ld_tab[k].ovr));
            step();
        end
        chk("load_tapwr_total", tw_cnt, NT);
        chk("load_done_total", done_cnt, 1);
        chk("ovr_sticky_idle", int'(bus.o_overrun), 1);

        // Reload both banks: bank 2 unchanged, bank 1 carries the mid-load write.
        bus.i_ce = 1'b0;
        do_load(2);
        do_load(1);

        // Asynchronous reset in the middle of a load.
        bus.i_ce        = 1'b1;
        bus.i_sample    = 9'd5;
        bus.i_load_bank = 2'd1;
        bus.i_load_req  = 1'b1;
        step();
        bus.i_load_req  = 1'b0;
        for (int k = 1; k < 8; k++) step();
        chk("midload_tapwr_before", int'(bus.o_tap_wr), 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ce", int'(bus.o_ce), 1);
        chk("post_rst_smp", int'(bus.o_sample), 5);
        step();
        chk("post_rst_busy", int'(bus.o_busy), 0);
        chk("post_rst_tapwr", int'(bus.o_tap_wr), 0);
        bus.i_ce = 1'b0;
        do_load(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
